bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit datapath bus.
- Accepts transfer requests from up to NUM_REQ requesters (control unit, in-port, memory interface, ALU writeback); each request names a bus source and a hold length.
- Grants the bus to one requester at a time and drives the one-hot Encoder_signals vector into the bus multiplexer's encoder for the required number of cycles.
- Guarantees a one-cycle idle gap between owners; rejects out-of-range source indices.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_SRC, 24, width of the one-hot Encoder_signals vector (bus sources 0..23; 23 = C_sign_extended).
- SEL_W, 5, width of each source index.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_src  input  NUM_REQ*SEL_W  source index for requester i, bits [i*SEL_W +: SEL_W].
- req_len  input  NUM_REQ*2  hold length for requester i, bits [i*2 +: 2]; hold = req_len+1 cycles (1..4).
- grant  output  NUM_REQ  one-hot current owner; zero when idle.
- done  output  NUM_REQ  one-cycle pulse to the owner on its last bus cycle.
- Encoder_signals  output  NUM_SRC  one-hot bus source select; zero when idle.
- bus_busy  output  1  high while a requester owns the bus.
- err_bad_src  output  1  one-cycle pulse when a winner's req_src >= NUM_SRC.

Behaviour:
- All outputs are registered.
- Reset (clear=1 at the edge):
  - grant=0, done=0, Encoder_signals=0, bus_busy=0, err_bad_src=0.
  - state=IDLE, round-robin pointer=0, hold counter=0.
  - Reset takes priority over every other event, including mid-transfer; no done is issued for an aborted owner.
- State IDLE:
  - Outputs are zero, except that done and err_bad_src may carry the pulse from the preceding cycle's completion.
  - If any req bit is set, select the winner by searching from index ptr upward, modulo NUM_REQ.
  - Next edge, valid source: grant=onehot(winner); Encoder_signals=onehot(req_src[winner]); bus_busy=1; counter=req_len[winner]; ptr=(winner+1) mod NUM_REQ; go to OWN.
  - Next edge, invalid source (req_src >= NUM_SRC): err_bad_src=1 and done[winner]=1 for one cycle; grant and Encoder_signals stay 0; ptr still advances; remain IDLE.
  - Latency: a request seen in IDLE at edge t gives grant and Encoder_signals valid from edge t+1.
- State OWN:
  - grant and Encoder_signals are held constant.
  - req_src and req_len are sampled only at grant time; later changes are ignored.
  - counter>0 and req[owner]=1: decrement counter.
  - counter==0 and req[owner]=1: this cycle is the last bus cycle and done[owner]=1 during it. At the next edge clear grant, Encoder_signals and bus_busy, and go to IDLE.
  - req[owner] drops while in OWN: abort. Next edge clears grant, Encoder_signals and bus_busy, no done is issued, go to IDLE; ptr keeps its advanced value.
  - Requests from non-owners are ignored; they wait, with no queueing beyond their held req level.
- Bus occupancy:
  - A transfer occupies exactly req_len+1 cycles with Encoder_signals non-zero.
  - This is followed by at least one IDLE cycle with Encoder_signals=0 (bus turnaround), so back-to-back grants are separated by exactly one zero cycle.
- Requester protocol: hold req high until done is seen, then drop it the following cycle. A req still high one cycle after done is treated as a new request.
- Invariants:
  - grant and Encoder_signals are each zero or one-hot.
  - bus_busy == |grant.
  - done is at most one-hot.

Test Plan:
- Reset then idle: clear=1 for 2 cycles, req=0 -> all outputs 0; no activity for 10 cycles.
- Single transfer: req=4'b0001, req_src[0]=0, req_len[0]=2 ->
  - grant=0001 and Encoder_signals=24'h000001 for 3 cycles, starting one cycle after req.
  - done[0] on the 3rd cycle.
  - then one cycle of Encoder_signals=0.
- Round-robin fairness: req=4'b1111 held; sources 1, 2, 23, 5; all req_len=0 ->
  - grant order 0001, 0010, 0100, 1000, each 1 cycle, separated by zero cycles.
  - Encoder_signals = 24'h000002, 24'h000004, 24'h800000, 24'h000020.
  - The order repeats on the next round.
- Bad source: req=4'b0010, req_src[1]=24 -> err_bad_src and done[1] pulse one cycle; grant=0 and Encoder_signals=0 throughout; the next winner is searched from index 2.
- Abort: requester 2 granted with req_len=3, req[2] dropped on the 2nd owned cycle -> the next edge clears grant and Encoder_signals, no done[2]; pending req[3] is granted after one idle cycle.
- Reset mid-transfer: clear=1 during the 2nd cycle of a 4-cycle grant to requester 0 -> next edge all outputs 0 and ptr=0; with req=4'b1001 still held after reset, requester 0 wins first.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection and hold sequencing
// for the shared 32-bit datapath bus encoder.
module bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEL_W-1:0] req_src,
  input  logic [NUM_REQ*2-1:0]     req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_SRC-1:0]       Encoder_signals,
  output logic                     bus_busy,
  output logic                     err_bad_src
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t state;
  state_t state_nx;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nx;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   owner_nx;
  logic [1:0]         cnt;
  logic [1:0]         cnt_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [NUM_REQ-1:0] done_nx;
  logic [NUM_SRC-1:0] enc_nx;
  logic               busy_nx;
  logic               err_nx;

  logic [SEL_W-1:0] src_arr [NUM_REQ];
  logic [1:0]       len_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign src_arr[g] = req_src[g*SEL_W +: SEL_W];
    assign len_arr[g] = req_len[g*2 +: 2];
  end

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  int                 t;
  logic [SEL_W-1:0]   win_src;
  logic [1:0]         win_len;
  logic               src_ok;
  logic [NUM_REQ-1:0] win_hot;

  // rotating priority search starting at ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    t     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = int'(ptr) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      cand = PTR_W'(t);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_src = src_arr[win];
  assign win_len = len_arr[win];
  assign src_ok  = int'(win_src) < NUM_SRC;
  assign win_hot = NUM_REQ'(1) << win;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    cnt_nx   = cnt;
    grant_nx = grant;
    enc_nx   = Encoder_signals;
    busy_nx  = bus_busy;
    done_nx  = '0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          ptr_nx = (win == PTR_W'(NUM_REQ - 1))
                 ? '0 : win + 1'b1;
          if (src_ok) begin
            state_nx = OWN;
            owner_nx = win;
            cnt_nx   = win_len;
            grant_nx = win_hot;
            enc_nx   = NUM_SRC'(1) << win_src;
            busy_nx  = 1'b1;
            done_nx  = (win_len == 2'd0) ? win_hot : '0;
          end else begin
            err_nx  = 1'b1;
            done_nx = win_hot;
          end
        end
      end
      OWN: begin
        // dropped req aborts; count exhausted completes
        if (!req[owner] || cnt == 2'd0) begin
          state_nx = IDLE;
          cnt_nx   = 2'd0;
          grant_nx = '0;
          enc_nx   = '0;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx  = cnt - 2'd1;
          done_nx = (cnt == 2'd1) ? grant : '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state           <= IDLE;
      ptr             <= '0;
      owner           <= '0;
      cnt             <= '0;
      grant           <= '0;
      done            <= '0;
      Encoder_signals <= '0;
      bus_busy        <= 1'b0;
      err_bad_src     <= 1'b0;
    end else begin
      state           <= state_nx;
      ptr             <= ptr_nx;
      owner           <= owner_nx;
      cnt             <= cnt_nx;
      grant           <= grant_nx;
      done            <= done_nx;
      Encoder_signals <= enc_nx;
      bus_busy        <= busy_nx;
      err_bad_src     <= err_nx;
    end
  end

  a_grant_hot: assert property (
    @(posedge clock) $onehot0(grant));
  a_enc_hot: assert property (
    @(posedge clock) $onehot0(Encoder_signals));
  a_done_hot: assert property (
    @(posedge clock) $onehot0(done));
  a_busy: assert property (
    @(posedge clock) bus_busy == |grant);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural arbiter model.
module tb_bus_arbiter;
  localparam int NR = 4;
  localparam int NS = 24;
  localparam int SW = 5;

  logic             clock = 1'b0;
  logic             clear;
  logic [NR-1:0]    req;
  logic [NR*SW-1:0] req_src;
  logic [NR*2-1:0]  req_len;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic [NS-1:0]    Encoder_signals;
  logic             bus_busy;
  logic             err_bad_src;

  int checks = 0;
  int fails  = 0;

  bus_arbiter #(.NUM_REQ(NR), .NUM_SRC(NS), .SEL_W(SW)) dut (
    .clock           (clock),
    .clear           (clear),
    .req             (req),
    .req_src         (req_src),
    .req_len         (req_len),
    .grant           (grant),
    .done            (done),
    .Encoder_signals (Encoder_signals),
    .bus_busy        (bus_busy),
    .err_bad_src     (err_bad_src)
  );

  always #5 clock = ~clock;

  // model: current owner (-1 idle), bus cycles left, next search start
  int          m_owner = -1;
  int          m_left  = 0;
  int          m_rr    = 0;
  int          m_src   = 0;
  logic [NR-1:0] m_pdone = '0;
  logic        m_perr  = 1'b0;

  task automatic model_edge();
    int i;
    int s;
    m_pdone = '0;
    m_perr  = 1'b0;
    if (clear) begin
      m_owner = -1;
      m_left  = 0;
      m_rr    = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (req[i]) begin
          s = int'(req_src[i*SW +: SW]);
          m_rr = (i + 1) % NR;
          if (s >= NS) begin
            m_perr = 1'b1;
            m_pdone[i] = 1'b1;
          end else begin
            m_owner = i;
            m_src   = s;
            m_left  = int'(req_len[i*2 +: 2]) + 1;
          end
          break;
        end
      end
    end else if (!req[m_owner] || m_left == 1) begin
      m_owner = -1;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  function automatic logic [33:0] exp_all();
    logic [NR-1:0] g;
    logic [NR-1:0] d;
    logic [NS-1:0] e;
    g = '0;
    e = '0;
    d = m_pdone;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      e[m_src]   = 1'b1;
      if (m_left == 1) d[m_owner] = 1'b1;
    end
    return {g, d, e, (m_owner >= 0), m_perr};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_req(input int i, input int src, input int len);
    req_src[i*SW +: SW] = SW'(src);
    req_len[i*2 +: 2]   = 2'(len);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    req   = '0;
    tick();
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    req   = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) clear = 1'b0;
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL reset c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
    end
  endtask

  task automatic test_single();
    int gcyc  = 0;
    int first = -1;
    int dcyc  = -1;
    logic drop = 1'b0;
    do_reset();
    set_req(0, 0, 2);
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL single c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
      if (grant == 4'b0001 && Encoder_signals == 24'h000001) begin
        gcyc++;
        if (first < 0) first = c;
      end
      if (done[0]) dcyc = c;
      if (drop) req[0] = 1'b0;
      drop = done[0];
    end
    checks++;
    if (first != 0 || gcyc != 3 || dcyc != 2) begin
      fails++;
      $display("FAIL single_shape first=%0d len=%0d done=%0d exp 0/3/2",
        first, gcyc, dcyc);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] gq [$];
    logic [NS-1:0] eq [$];
    logic [NS-1:0] etab [4];
    logic [NR-1:0] ge;
    etab[0] = 24'h000002;
    etab[1] = 24'h000004;
    etab[2] = 24'h800000;
    etab[3] = 24'h000020;
    do_reset();
    set_req(0, 1, 0);
    set_req(1, 2, 0);
    set_req(2, 23, 0);
    set_req(3, 5, 0);
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL rr c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
      if (grant != '0) begin
        gq.push_back(grant);
        eq.push_back(Encoder_signals);
      end
    end
    req = '0;
    checks++;
    if (gq.size() != 8) begin
      fails++;
      $display("FAIL rr_count got=%0d exp=8", gq.size());
    end
    for (int k = 0; k < gq.size() && k < 8; k++) begin
      ge = 4'b0001 << (k % 4);
      checks++;
      if (gq[k] !== ge || eq[k] !== etab[k % 4]) begin
        fails++;
        $display("FAIL rr_order k%0d got=%b/%h exp=%b/%h",
          k, gq[k], eq[k], ge, etab[k % 4]);
      end
    end
  endtask

  task automatic test_bad_src();
    do_reset();
    set_req(1, 24, 1);
    req = 4'b0010;
    tick();
    checks++;
    if (err_bad_src !== 1'b1 || done !== 4'b0010 ||
        grant !== '0 || Encoder_signals !== '0) begin
      fails++;
      $display("FAIL bad_src got err=%b done=%b g=%b e=%h exp 1/0010/0/0",
        err_bad_src, done, grant, Encoder_signals);
    end
    set_req(0, 1, 0);
    set_req(1, 3, 0);
    set_req(2, 4, 0);
    set_req(3, 5, 0);
    req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0100 || err_bad_src !== 1'b0 ||
        done !== 4'b0100) begin
      fails++;
      $display("FAIL bad_next got g=%b err=%b done=%b exp 0100/0/0100",
        grant, err_bad_src, done);
    end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL bad_tail c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    set_req(2, 7, 3);
    set_req(3, 9, 1);
    req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL abort c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
      if (c == 2) begin
        checks++;
        if (grant !== '0 || Encoder_signals !== '0 || done !== '0) begin
          fails++;
          $display("FAIL abort_clear got g=%b e=%h d=%b exp 0/0/0",
            grant, Encoder_signals, done);
        end
      end
      if (c == 3) begin
        checks++;
        if (grant !== 4'b1000 || Encoder_signals !== 24'h000200) begin
          fails++;
          $display("FAIL abort_next got g=%b e=%h exp 1000/000200",
            grant, Encoder_signals);
        end
      end
      if (c == 0) req = 4'b1100;
      if (c == 1) req[2] = 1'b0;
      if (c == 5) req = '0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 4, 3);
    set_req(3, 6, 0);
    req = 4'b0001;
    tick();
    tick();
    clear = 1'b1;
    req   = 4'b1001;
    tick();
    checks++;
    if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
        !== 34'd0) begin
      fails++;
      $display("FAIL mid_reset got=%h exp=0",
        {grant, done, Encoder_signals, bus_busy, err_bad_src});
    end
    clear = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || Encoder_signals !== 24'h000010) begin
      fails++;
      $display("FAIL mid_first got g=%b e=%h exp 0001/000010",
        grant, Encoder_signals);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL mid_tail c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] last_done;
    last_done = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tick();
      checks++;
      if ({grant, done, Encoder_signals, bus_busy, err_bad_src}
          !== exp_all()) begin
        fails++;
        $display("FAIL random c%0d got=%h exp=%h", c,
          {grant, done, Encoder_signals, bus_busy, err_bad_src},
          exp_all());
      end
      for (int i = 0; i < NR; i++) begin
        if (last_done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            set_req(i, int'($urandom_range(27)), int'($urandom_range(3)));
          end
        end else if (grant[i] && $urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          set_req(i, int'($urandom_range(27)), int'($urandom_range(3)));
        end
      end
      last_done = done;
      clear = ($urandom_range(99) == 0);
    end
    clear = 1'b0;
    req   = '0;
  endtask

  initial begin
    clear   = 1'b1;
    req     = '0;
    req_src = '0;
    req_len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_bad_src();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
